// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: comparator funct3 codes, the 2-bit
// saturating counter type with its update rule, and predictor FSM states.
package branch_pkg;

    // Conditional branch funct3 encodings used by the execute-stage comparator.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bimodal counter: bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_state_t;

    // Saturating step toward the resolved outcome.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t r;
        r = ctr;
        if (taken) begin
            if (ctr != ST) r = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) r = ctr_t'(ctr - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor storage: ENTRIES x {valid, tag, ctr, target[31:2]}.
// Ports: rd_a_* async read (fetch lookup), rd_b_* async read (execute
// read-modify-write of the counter), wr_* single synchronous write port.
// The array has no reset; the owner clears valid bits by walking the table.
module bp_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_a_idx,
    output logic             rd_a_valid,
    output logic [TAG_W-1:0] rd_a_tag,
    output ctr_t             rd_a_ctr,
    output logic [29:0]      rd_a_target,
    input  logic [IDX_W-1:0] rd_b_idx,
    output logic             rd_b_valid,
    output logic [TAG_W-1:0] rd_b_tag,
    output ctr_t             rd_b_ctr,
    output logic [29:0]      rd_b_target,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  ctr_t             wr_ctr,
    input  logic [29:0]      wr_target
);

    logic             valid_mem  [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    ctr_t             ctr_mem    [ENTRIES];
    logic [29:0]      target_mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            valid_mem[wr_idx]  <= wr_valid;
            tag_mem[wr_idx]    <= wr_tag;
            ctr_mem[wr_idx]    <= wr_ctr;
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_a_valid  = valid_mem[rd_a_idx];
    assign rd_a_tag    = tag_mem[rd_a_idx];
    assign rd_a_ctr    = ctr_mem[rd_a_idx];
    assign rd_a_target = target_mem[rd_a_idx];

    assign rd_b_valid  = valid_mem[rd_b_idx];
    assign rd_b_tag    = tag_mem[rd_b_idx];
    assign rd_b_ctr    = ctr_mem[rd_b_idx];
    assign rd_b_target = target_mem[rd_b_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side bimodal predictor with direct-mapped BTB.
// Ports: clk/rst (sync, active high); lookup_valid/lookup_pc in, registered
// pred_valid/pred_taken/pred_target/pred_ready out one cycle later;
// update_valid/update_pc/update_taken/update_target train the table.
// After reset the FSM walks every index clearing valid, then enters S_RUN.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_ready,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] walk_idx_q, walk_idx_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [31:0]      pred_target_q, pred_target_d;
    logic             pred_ready_q, pred_ready_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    logic             a_valid, b_valid;
    logic [TAG_W-1:0] a_tag, b_tag;
    ctr_t             a_ctr, b_ctr;
    logic [29:0]      a_target, b_target;

    logic             we;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    ctr_t             wr_ctr;
    logic [29:0]      wr_target;

    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    ctr_t             e_ctr;
    logic [29:0]      e_target;
    logic             lk_taken;

    // Only the index/tag fields of the PCs and target[31:2] carry meaning.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc, update_pc, update_target[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];

    bp_table #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_table (
        .clk         (clk),
        .rd_a_idx    (lk_idx),
        .rd_a_valid  (a_valid),
        .rd_a_tag    (a_tag),
        .rd_a_ctr    (a_ctr),
        .rd_a_target (a_target),
        .rd_b_idx    (up_idx),
        .rd_b_valid  (b_valid),
        .rd_b_tag    (b_tag),
        .rd_b_ctr    (b_ctr),
        .rd_b_target (b_target),
        .we          (we),
        .wr_idx      (wr_idx),
        .wr_valid    (wr_valid),
        .wr_tag      (wr_tag),
        .wr_ctr      (wr_ctr),
        .wr_target   (wr_target)
    );

    // Write port: init walk owns it in S_INIT, execute training in S_RUN.
    always_comb begin
        we        = 1'b0;
        wr_idx    = up_idx;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_ctr    = WT;
        wr_target = update_target[31:2];
        if (state_q == S_INIT) begin
            we        = 1'b1;
            wr_idx    = walk_idx_q;
            wr_valid  = 1'b0;
            wr_tag    = '0;
            wr_ctr    = SNT;
            wr_target = '0;
        end else if (update_valid) begin
            if (b_valid && (b_tag == up_tag)) begin
                we     = 1'b1;
                wr_ctr = sat_update(b_ctr, update_taken);
                // A not-taken outcome keeps the last known target.
                if (!update_taken) wr_target = b_target;
            end else if (update_taken) begin
                we = 1'b1;
            end
        end
    end

    // Write-first bypass: a same-index update is visible to this lookup.
    // Walk writes are excluded; in S_INIT the prediction is forced not taken.
    always_comb begin
        e_valid  = a_valid;
        e_tag    = a_tag;
        e_ctr    = a_ctr;
        e_target = a_target;
        if (we && (state_q == S_RUN) && (wr_idx == lk_idx)) begin
            e_valid  = wr_valid;
            e_tag    = wr_tag;
            e_ctr    = wr_ctr;
            e_target = wr_target;
        end
        lk_taken = (state_q == S_RUN) && e_valid && (e_tag == lk_tag) && e_ctr[1];
    end

    always_comb begin
        state_d       = state_q;
        walk_idx_d    = walk_idx_q;
        pred_valid_d  = lookup_valid;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (state_q == S_INIT) begin
            walk_idx_d = walk_idx_q + 1'b1;
            if (walk_idx_q == IDX_W'(ENTRIES - 1)) state_d = S_RUN;
        end
        if (lookup_valid) begin
            pred_taken_d  = lk_taken;
            pred_target_d = lk_taken ? {e_target, 2'b00} : lookup_pc + 32'd4;
        end
        pred_ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            walk_idx_q    <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            walk_idx_q    <= walk_idx_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_ready_q  <= pred_ready_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign pred_ready  = pred_ready_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a table model
// that works on plain integer indices/tags and counter values 0..3.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_ready;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    int vectors = 0;
    int miscompares = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ready    (pred_ready),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          n_since_rst = 0;
    bit          chk_en = 0;
    logic        exp_valid, exp_taken, exp_ready;
    logic [31:0] exp_target;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            n_since_rst = 0;
            exp_valid = 0; exp_taken = 0; exp_target = 0; exp_ready = 0;
            chk_en = 1;
        end else begin
            automatic bit ready = (n_since_rst >= ENTRIES);
            if (ready && update_valid) begin
                automatic int ui = idx_of(update_pc);
                automatic int ut = tag_of(update_pc);
                if (m_valid[ui] && m_tag[ui] == ut) begin
                    if (update_taken) begin
                        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                        m_tgt[ui] = update_target & 32'hFFFF_FFFC;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                    end
                end else if (update_taken) begin
                    m_valid[ui] = 1; m_tag[ui] = ut; m_ctr[ui] = 2;
                    m_tgt[ui] = update_target & 32'hFFFF_FFFC;
                end
            end
            // Lookup after the update: same-index lookups see the new entry.
            exp_valid = lookup_valid;
            if (lookup_valid) begin
                automatic int li = idx_of(lookup_pc);
                automatic bit hit = m_valid[li] && (m_tag[li] == tag_of(lookup_pc));
                exp_taken  = ready && hit && (m_ctr[li] >= 2);
                exp_target = exp_taken ? m_tgt[li] : lookup_pc + 32'd4;
            end
            if (n_since_rst < 100000) n_since_rst++;
            exp_ready = (n_since_rst >= ENTRIES);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.pred_valid",  32'(pred_valid),  32'(exp_valid));
            chk("model.pred_taken",  32'(pred_taken),  32'(exp_taken));
            chk("model.pred_target", pred_target,      exp_target);
            chk("model.pred_ready",  32'(pred_ready),  32'(exp_ready));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        lookup_valid = lv; lookup_pc = lpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_target = utg;
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b0, 32'h0, 1'b1, pc, t, tg);
    endtask

    task automatic expect_pred(input string name, input logic t, input logic [31:0] tg);
        chk({name, ".valid"},  32'(pred_valid), 32'd1);
        chk({name, ".taken"},  32'(pred_taken), 32'(t));
        chk({name, ".target"}, pred_target, tg);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 7) == 0) pc = $urandom;
        else if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
        else pc = (32'($urandom_range(0, 3)) << (2 + IDX_W)) |
                  (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        rst = 1'b1;
        lookup_valid = 0; lookup_pc = 0;
        update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0;

        // T1: reset then init walk
        idle(); idle();
        chk("T1.reset_valid",  32'(pred_valid),  32'd0);
        chk("T1.reset_target", pred_target,      32'd0);
        chk("T1.reset_ready",  32'(pred_ready),  32'd0);
        rst = 1'b0;
        for (int k = 1; k <= ENTRIES; k++) begin
            if (k == 5) begin
                look(32'h100);
                expect_pred("T1.init_lookup", 1'b0, 32'h104);
            end else begin
                idle();
            end
            if (k == ENTRIES - 1) chk("T1.ready_low",  32'(pred_ready), 32'd0);
            if (k == ENTRIES)     chk("T1.ready_high", 32'(pred_ready), 32'd1);
        end

        // T2: allocate; not-taken miss does not allocate
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100); expect_pred("T2.alloc", 1'b1, 32'h80);
        upd(32'h200, 1'b0, 32'h999);
        look(32'h200); expect_pred("T2.nt_miss", 1'b0, 32'h204);

        // T3: hysteresis
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100); expect_pred("T3.wnt", 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100); expect_pred("T3.wt", 1'b1, 32'h80);
        repeat (3) upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100); expect_pred("T3.st_nt", 1'b1, 32'h80);

        // T4: alias at same index, different tag; non-aligned target low bits dropped
        look(32'h100 + ENTRIES * 4); expect_pred("T4.alias_miss", 1'b0, 32'h204);
        upd(32'h100 + ENTRIES * 4, 1'b1, 32'h93);
        look(32'h100); expect_pred("T4.orig_miss", 1'b0, 32'h104);
        look(32'h100 + ENTRIES * 4); expect_pred("T4.alias_hit", 1'b1, 32'h90);

        // T5: same-cycle bypass, and pc+4 wrap
        step(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h40);
        expect_pred("T5.bypass", 1'b1, 32'h40);
        look(32'hFFFF_FFFC); expect_pred("T5.wrap", 1'b0, 32'h0);
        idle();
        chk("T5.hold_valid",  32'(pred_valid), 32'd0);
        chk("T5.hold_target", pred_target,     32'h0);

        // T6: reset mid-run drops the in-flight lookup and clears the table
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100); expect_pred("T6.trained", 1'b1, 32'h80);
        rst = 1'b1;
        look(32'h100);
        chk("T6.dropped", 32'(pred_valid), 32'd0);
        rst = 1'b0;
        repeat (ENTRIES) idle();
        look(32'h100); expect_pred("T6.cleared", 1'b0, 32'h104);

        // Random traffic, checked each cycle by the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 3) != 0, rand_pc(),
                 $urandom_range(0, 1) == 1, rand_pc(),
                 $urandom_range(0, 2) != 0, $urandom);
        end
        rst = 1'b0;
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
